// File: rtl/seg7_scan_decoder.sv
// Reader for a multiplexed active-low seven-segment bus: waits for each strobed glyph
// to settle, decodes it back to a 4-bit code per slot and reports completed scan frames.
module seg7_scan_decoder #(
   parameter int DIGITS        = 4,
   parameter int STABLE_CYCLES = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [6:0]            seg_n,
   input  logic [DIGITS-1:0]     an_n,
   output logic [4*DIGITS-1:0]   digit_bcd,
   output logic [DIGITS-1:0]     digit_blank,
   output logic [DIGITS-1:0]     digit_err,
   output logic                  upd,
   output logic [2:0]            upd_idx,
   output logic                  frame_valid
);

   localparam int                CW         = (STABLE_CYCLES < 2) ? 1 : $clog2(STABLE_CYCLES + 1);
   localparam logic [CW-1:0]     CNT_ONE    = CW'(1);
   localparam logic [CW-1:0]     CNT_TARGET = CW'(STABLE_CYCLES);
   localparam logic [DIGITS-1:0] MASK_FULL  = '1;
   localparam logic [6:0]        SEG_DARK   = 7'b111_1111;

   typedef enum logic [1:0] {
      WAIT,
      SETTLE,
      HOLD
   } state_t;

   state_t              state;
   state_t              state_next;
   logic [CW-1:0]       cnt;
   logic [CW-1:0]       cnt_next;
   logic                capture;

   logic [6:0]          seg_q;
   logic [DIGITS-1:0]   an_q;
   logic [6:0]          seg_prev;
   logic [DIGITS-1:0]   an_prev;
   logic [DIGITS-1:0]   seen;

   logic [3:0]          act_cnt;
   logic [2:0]          act_idx;
   logic                legal;
   logic                changed;
   logic [DIGITS-1:0]   slot_onehot;
   logic [DIGITS-1:0]   seen_next;
   logic [4:0]          dec;

   // Idle bus reads as all-dark with no strobe, so the first real sample looks like a change.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seg_q    <= '1;
         an_q     <= '1;
         seg_prev <= '1;
         an_prev  <= '1;
      end else begin
         seg_q    <= seg_n;
         an_q     <= an_n;
         seg_prev <= seg_q;
         an_prev  <= an_q;
      end
   end

   always_comb begin
      act_cnt = '0;
      act_idx = '0;
      for (int i = 0; i < DIGITS; i++) begin
         if (!an_q[i]) begin
            act_cnt = act_cnt + 4'd1;
            act_idx = 3'(i);
         end
      end
   end

   assign legal       = (act_cnt == 4'd1);
   assign changed     = ({an_q, seg_q} != {an_prev, seg_prev});
   assign slot_onehot = ~an_q;
   assign seen_next   = seen | slot_onehot;

   function automatic logic [4:0] decode(input logic [6:0] p);
      case (p)
         7'b000_0001: decode = {1'b1, 4'h0};
         7'b100_1111: decode = {1'b1, 4'h1};
         7'b001_0010: decode = {1'b1, 4'h2};
         7'b000_0110: decode = {1'b1, 4'h3};
         7'b100_1100: decode = {1'b1, 4'h4};
         7'b010_0100: decode = {1'b1, 4'h5};
         7'b010_0000: decode = {1'b1, 4'h6};
         7'b000_1111: decode = {1'b1, 4'h7};
         7'b000_0000: decode = {1'b1, 4'h8};
         7'b000_0100: decode = {1'b1, 4'h9};
         7'b000_1101: decode = {1'b1, 4'hA};
         7'b001_1001: decode = {1'b1, 4'hB};
         7'b010_0011: decode = {1'b1, 4'hC};
         7'b100_1011: decode = {1'b1, 4'hD};
         default:     decode = {1'b0, 4'h0};
      endcase
   endfunction

   assign dec = decode(seg_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= WAIT;
         cnt   <= '0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
      end
   end

   // Any path that lands in SETTLE with the counter at target captures on this edge instead.
   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      capture    = 1'b0;
      case (state)
         WAIT: begin
            cnt_next = '0;
            if (legal) begin
               state_next = SETTLE;
               cnt_next   = CNT_ONE;
            end
         end
         SETTLE: begin
            if (!legal) begin
               state_next = WAIT;
               cnt_next   = '0;
            end else if (changed) begin
               cnt_next = CNT_ONE;
            end else begin
               cnt_next = cnt + CNT_ONE;
            end
         end
         HOLD: begin
            if (changed) begin
               if (legal) begin
                  state_next = SETTLE;
                  cnt_next   = CNT_ONE;
               end else begin
                  state_next = WAIT;
                  cnt_next   = '0;
               end
            end
         end
         default: begin
            state_next = WAIT;
            cnt_next   = '0;
         end
      endcase
      if (state_next == SETTLE && cnt_next == CNT_TARGET) begin
         capture    = 1'b1;
         state_next = HOLD;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         digit_bcd   <= '0;
         digit_blank <= '0;
         digit_err   <= '0;
         upd         <= 1'b0;
         upd_idx     <= '0;
         frame_valid <= 1'b0;
         seen        <= '0;
      end else begin
         upd         <= 1'b0;
         frame_valid <= 1'b0;
         if (capture) begin
            upd     <= 1'b1;
            upd_idx <= act_idx;
            for (int i = 0; i < DIGITS; i++) begin
               if (slot_onehot[i]) begin
                  if (dec[4]) begin
                     digit_bcd[4*i +: 4] <= dec[3:0];
                     digit_blank[i]      <= 1'b0;
                     digit_err[i]        <= 1'b0;
                  end else if (seg_q == SEG_DARK) begin
                     digit_bcd[4*i +: 4] <= 4'h0;
                     digit_blank[i]      <= 1'b1;
                     digit_err[i]        <= 1'b0;
                  end else begin
                     digit_blank[i]      <= 1'b0;
                     digit_err[i]        <= 1'b1;
                  end
               end
            end
            if (seen_next == MASK_FULL) begin
               frame_valid <= 1'b1;
               seen        <= '0;
            end else begin
               seen        <= seen_next;
            end
         end
      end
   end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed bench for seg7_scan_decoder: drives strobe/segment patterns and
// compares captures, frame pulses and decoded slots against hand-computed values.
module tb_seg7_scan_decoder;

   localparam logic [6:0] S1 = 7'b100_1111;
   localparam logic [6:0] S2 = 7'b001_0010;
   localparam logic [6:0] S3 = 7'b000_0110;
   localparam logic [6:0] S4 = 7'b100_1100;
   localparam logic [6:0] S5 = 7'b010_0100;
   localparam logic [6:0] S6 = 7'b010_0000;
   localparam logic [6:0] SDARK = 7'b111_1111;

   logic        clk;
   logic        rst_n;
   logic [6:0]  seg_n;
   logic [3:0]  an_n;
   logic [15:0] digit_bcd;
   logic [3:0]  digit_blank;
   logic [3:0]  digit_err;
   logic        upd;
   logic [2:0]  upd_idx;
   logic        frame_valid;

   int checks_total;
   int checks_passed;

   int obs_upd;
   int obs_first_edge;
   int obs_idx;
   int obs_frames;
   int obs_frame_alone;

   seg7_scan_decoder #(.DIGITS(4), .STABLE_CYCLES(4)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .seg_n       (seg_n),
      .an_n        (an_n),
      .digit_bcd   (digit_bcd),
      .digit_blank (digit_blank),
      .digit_err   (digit_err),
      .upd         (upd),
      .upd_idx     (upd_idx),
      .frame_valid (frame_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks_total++;
      if (actual === expected) begin
         checks_passed++;
      end else begin
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
      end
   endtask

   // Drives one pattern for a fixed number of edges and records what the DUT reported.
   task automatic applyStimulus(input logic [3:0] an, input logic [6:0] seg, input int cycles);
      obs_upd         = 0;
      obs_first_edge  = 0;
      obs_idx         = -1;
      obs_frames      = 0;
      obs_frame_alone = 0;
      an_n  = an;
      seg_n = seg;
      for (int k = 1; k <= cycles; k++) begin
         @(posedge clk);
         #1;
         if (upd) begin
            obs_upd++;
            if (obs_first_edge == 0) obs_first_edge = k;
            obs_idx = int'(upd_idx);
         end
         if (frame_valid) begin
            obs_frames++;
            if (!upd) obs_frame_alone++;
         end
      end
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_bcd"},   32'(digit_bcd),   32'h0);
      checkOutput({tag, "_blank"}, 32'(digit_blank), 32'h0);
      checkOutput({tag, "_err"},   32'(digit_err),   32'h0);
      checkOutput({tag, "_upd"},   32'(upd),         32'h0);
      checkOutput({tag, "_idx"},   32'(upd_idx),     32'h0);
      checkOutput({tag, "_frame"}, 32'(frame_valid), 32'h0);
   endtask

   task automatic scanSlot(input string tag, input int slot, input logic [6:0] seg, input int exp_frames);
      logic [3:0] an;
      an = 4'b1111;
      an[slot] = 1'b0;
      applyStimulus(an, seg, 8);
      checkOutput({tag, "_upd"},    32'(obs_upd),    32'd1);
      checkOutput({tag, "_idx"},    32'(obs_idx),    32'(slot));
      checkOutput({tag, "_frames"}, 32'(obs_frames), 32'(exp_frames));
   endtask

   initial begin
      checks_total  = 0;
      checks_passed = 0;
      rst_n = 1'b0;
      an_n  = 4'b1111;
      seg_n = SDARK;
      repeat (3) @(posedge clk);
      #1;
      checkAllZero("reset");
      rst_n = 1'b1;

      // Static digit: capture lands on the fifth edge and only once.
      applyStimulus(4'b1110, S3, 20);
      checkOutput("static_upd",    32'(obs_upd),        32'd1);
      checkOutput("static_edge",   32'(obs_first_edge), 32'd5);
      checkOutput("static_idx",    32'(obs_idx),        32'd0);
      checkOutput("static_nib",    32'(digit_bcd[3:0]), 32'h3);
      checkOutput("static_frames", 32'(obs_frames),     32'd0);

      // Two full scans; slot 0 was already seen, so the frame closes on slot 3 each time.
      for (int pass = 0; pass < 2; pass++) begin
         scanSlot("scan_s0", 0, S1, 0);
         scanSlot("scan_s1", 1, S2, 0);
         scanSlot("scan_s2", 2, S3, 0);
         scanSlot("scan_s3", 3, S4, 1);
         checkOutput("scan_frame_with_upd", 32'(obs_frame_alone), 32'd0);
         checkOutput("scan_bcd",            32'(digit_bcd),       32'h4321);
      end

      // Glitch: a short-lived 5 is replaced by 6 before it can settle.
      applyStimulus(4'b1101, S5, 2);
      checkOutput("glitch_pre_upd", 32'(obs_upd), 32'd0);
      applyStimulus(4'b1101, S6, 10);
      checkOutput("glitch_upd",  32'(obs_upd),        32'd1);
      checkOutput("glitch_edge", 32'(obs_first_edge), 32'd5);
      checkOutput("glitch_bcd",  32'(digit_bcd),      32'h4361);

      applyStimulus(4'b1100, S2, 10);
      checkOutput("illegal_two_upd", 32'(obs_upd), 32'd0);
      applyStimulus(4'b1111, S2, 10);
      checkOutput("illegal_none_upd", 32'(obs_upd), 32'd0);

      applyStimulus(4'b1011, SDARK, 10);
      checkOutput("blank_upd",   32'(obs_upd),     32'd1);
      checkOutput("blank_idx",   32'(obs_idx),     32'd2);
      checkOutput("blank_flags", 32'(digit_blank), 32'b0100);
      checkOutput("blank_err",   32'(digit_err),   32'b0000);
      checkOutput("blank_bcd",   32'(digit_bcd),   32'h4061);

      applyStimulus(4'b1011, 7'b111_0000, 10);
      checkOutput("err_upd",   32'(obs_upd),     32'd1);
      checkOutput("err_flags", 32'(digit_err),   32'b0100);
      checkOutput("err_blank", 32'(digit_blank), 32'b0000);
      checkOutput("err_bcd",   32'(digit_bcd),   32'h4061);

      applyStimulus(4'b0111, 7'b000_1111, 8);
      checkOutput("dec_7", 32'(digit_bcd[15:12]), 32'h7);
      applyStimulus(4'b0111, 7'b000_0000, 8);
      checkOutput("dec_8", 32'(digit_bcd[15:12]), 32'h8);
      applyStimulus(4'b0111, 7'b010_0011, 8);
      checkOutput("dec_C", 32'(digit_bcd[15:12]), 32'hC);
      applyStimulus(4'b0111, 7'b100_1011, 8);
      checkOutput("dec_D",        32'(digit_bcd[15:12]), 32'hD);
      checkOutput("dec_frames",   32'(obs_frames),       32'd0);
      checkOutput("dec_err_flag", 32'(digit_err),        32'b0100);

      // Mid-settle reset after two captures clears everything at once.
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
      scanSlot("mid_s0", 0, S1, 0);
      scanSlot("mid_s1", 1, S2, 0);
      applyStimulus(4'b1011, S3, 3);
      checkOutput("mid_settle_upd", 32'(obs_upd), 32'd0);
      #2;
      rst_n = 1'b0;
      #1;
      checkAllZero("mid_reset");
      #3;
      rst_n = 1'b1;
      scanSlot("post_s2", 2, S3, 0);
      scanSlot("post_s3", 3, S4, 0);
      scanSlot("post_s0", 0, S1, 0);
      scanSlot("post_s1", 1, S2, 1);
      checkOutput("post_bcd", 32'(digit_bcd), 32'h4321);

      $display("[TB] %0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end

endmodule
